// File: rtl/dll_pkg.sv
// Data link layer shared definitions: link states, packet types, payload widths
// and the TX arbiter FSM states. Also used by the TX TLP generator.
package dll_pkg;

  localparam int TLP_W  = 1196;
  localparam int DLLP_W = 48;

  typedef enum logic [1:0] {
    DLC_INACTIVE  = 2'b00,
    DLC_FEATURE   = 2'b01,
    DLC_DL_INIT   = 2'b10,
    DLC_DL_ACTIVE = 2'b11
  } dlc_state_e;

  typedef enum logic [1:0] {
    PKT_NONE   = 2'b00,
    PKT_TLP    = 2'b01,
    PKT_ACKNAK = 2'b10,
    PKT_FC     = 2'b11
  } pkt_type_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic acknak;
    logic fc;
    logic tlp;
  } req_vec_t;

endpackage

// File: rtl/dll_tx_arbiter_if.sv
// Bundle of the TX arbiter's requester and downstream handshakes.
// The master modport is the arbiter's view; slave is the surrounding logic.
interface dll_tx_arbiter_if;
  import dll_pkg::*;

  logic [1:0]        dlc_state;
  logic [TLP_W-1:0]  tlp;
  logic              tlp_valid;
  logic              tlp_ready;
  logic [DLLP_W-1:0] acknak;
  logic              acknak_valid;
  logic              acknak_ready;
  logic [DLLP_W-1:0] fc;
  logic              fc_valid;
  logic              fc_ready;
  logic [TLP_W-1:0]  pkt;
  logic [1:0]        pkt_type;
  logic              pkt_valid;
  logic              pkt_ready;

  modport master (
    input  dlc_state, tlp, tlp_valid, acknak, acknak_valid, fc, fc_valid, pkt_ready,
    output tlp_ready, acknak_ready, fc_ready, pkt, pkt_type, pkt_valid
  );

  modport slave (
    output dlc_state, tlp, tlp_valid, acknak, acknak_valid, fc, fc_valid, pkt_ready,
    input  tlp_ready, acknak_ready, fc_ready, pkt, pkt_type, pkt_valid
  );

endinterface

// File: rtl/dll_tx_arb_pick.sv
// Combinational winner select: Ack/Nak > FC > TLP, with a starved TLP
// promoted above FC but never above Ack/Nak. Requests are already eligibility-qualified.
module dll_tx_arb_pick
  import dll_pkg::*;
(
  input  req_vec_t req_i,
  input  logic     tlp_promote_i,
  output req_vec_t gnt_o
);

  always_comb begin
    gnt_o = '0;
    if (req_i.acknak)                    gnt_o.acknak = 1'b1;
    else if (req_i.tlp && tlp_promote_i) gnt_o.tlp    = 1'b1;
    else if (req_i.fc)                   gnt_o.fc     = 1'b1;
    else if (req_i.tlp)                  gnt_o.tlp    = 1'b1;
  end

endmodule

// File: rtl/dll_tx_arbiter.sv
// DLL TX arbiter: merges Ack/Nak, FC and TLP streams into one registered output slot.
// Define DLL_TX_ARB_STARVE_EN to enable TLP starvation promotion over FC.
module dll_tx_arbiter
  import dll_pkg::*;
#(
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        dlc_state_i,
  input  logic [TLP_W-1:0]  tlp_i,
  input  logic              tlp_valid_i,
  output logic              tlp_ready_o,
  input  logic [DLLP_W-1:0] acknak_i,
  input  logic              acknak_valid_i,
  output logic              acknak_ready_o,
  input  logic [DLLP_W-1:0] fc_i,
  input  logic              fc_valid_i,
  output logic              fc_ready_o,
  output logic [TLP_W-1:0]  pkt_o,
  output logic [1:0]        pkt_type_o,
  output logic              pkt_valid_o,
  input  logic              pkt_ready_i
);

  arb_state_e       state_q, state_d;
  pkt_type_e        type_q, type_d;
  logic [TLP_W-1:0] pkt_q, pkt_d;
  req_vec_t         req, gnt_raw, gnt;
  logic             grant_en;
  logic             tlp_promote;

  // FC is allowed during DL_INIT for InitFC; everything else needs DL_ACTIVE
  always_comb begin
    req.acknak = acknak_valid_i && (dlc_state_i == DLC_DL_ACTIVE);
    req.fc     = fc_valid_i && ((dlc_state_i == DLC_DL_INIT) || (dlc_state_i == DLC_DL_ACTIVE));
    req.tlp    = tlp_valid_i && (dlc_state_i == DLC_DL_ACTIVE);
  end

  dll_tx_arb_pick u_pick (
    .req_i         (req),
    .tlp_promote_i (tlp_promote),
    .gnt_o         (gnt_raw)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (gnt != '0)                              state_d = ST_HOLD;
    else if (state_q == ST_HOLD && pkt_ready_i) state_d = ST_EMPTY;
  end

  // A grant is only possible when the slot is free or drains this cycle
  always_comb begin
    grant_en       = rst_n && ((state_q == ST_EMPTY) || pkt_ready_i);
    gnt            = grant_en ? gnt_raw : '0;
    acknak_ready_o = gnt.acknak;
    fc_ready_o     = gnt.fc;
    tlp_ready_o    = gnt.tlp;
    pkt_d          = pkt_q;
    type_d         = type_q;
    if (gnt.acknak) begin
      pkt_d  = TLP_W'(acknak_i);
      type_d = PKT_ACKNAK;
    end else if (gnt.fc) begin
      pkt_d  = TLP_W'(fc_i);
      type_d = PKT_FC;
    end else if (gnt.tlp) begin
      pkt_d  = tlp_i;
      type_d = PKT_TLP;
    end else if (state_q == ST_HOLD && pkt_ready_i) begin
      type_d = PKT_NONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_q  <= '0;
      type_q <= PKT_NONE;
    end else begin
      pkt_q  <= pkt_d;
      type_q <= type_d;
    end
  end

  assign pkt_o       = pkt_q;
  assign pkt_type_o  = type_q;
  assign pkt_valid_o = (state_q == ST_HOLD);

`ifdef DLL_TX_ARB_STARVE_EN
  logic [3:0] starve_q, starve_d;

  // Counts opportunities a waiting, eligible TLP lost; saturates at 15
  always_comb begin
    starve_d = starve_q;
    if (!tlp_valid_i || gnt.tlp)                        starve_d = '0;
    else if (req.tlp && grant_en && starve_q != 4'hF)   starve_d = starve_q + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) starve_q <= '0;
    else        starve_q <= starve_d;
  end

  assign tlp_promote = (int'(starve_q) >= STARVE_LIMIT);
`else
  logic unused_starve_limit;
  assign unused_starve_limit = (STARVE_LIMIT != 0);
  assign tlp_promote         = 1'b0;
`endif

endmodule

// File: tb/tb_dll_tx_arbiter.sv
// Self-checking bench for dll_tx_arbiter: vector table, directed corner sequences
// and a randomized run against a priority-list reference model.
module tb_dll_tx_arbiter;
  import dll_pkg::*;

`ifdef DLL_TX_ARB_STARVE_EN
  localparam bit STARVE = 1'b1;
`else
  localparam bit STARVE = 1'b0;
`endif
  localparam int LIMIT = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dll_tx_arbiter_if bus ();

  dll_tx_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .dlc_state_i    (bus.dlc_state),
    .tlp_i          (bus.tlp),
    .tlp_valid_i    (bus.tlp_valid),
    .tlp_ready_o    (bus.tlp_ready),
    .acknak_i       (bus.acknak),
    .acknak_valid_i (bus.acknak_valid),
    .acknak_ready_o (bus.acknak_ready),
    .fc_i           (bus.fc),
    .fc_valid_i     (bus.fc_valid),
    .fc_ready_o     (bus.fc_ready),
    .pkt_o          (bus.pkt),
    .pkt_type_o     (bus.pkt_type),
    .pkt_valid_o    (bus.pkt_valid),
    .pkt_ready_i    (bus.pkt_ready)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_pkt(input string nm, input logic [TLP_W-1:0] exp);
    total++;
    if (bus.pkt !== exp) begin
      bad++;
      $display("FAIL %s: pkt low 64 got %h want %h (t=%0t)", nm, bus.pkt[63:0], exp[63:0], $time);
    end
  endtask

  function automatic logic [TLP_W-1:0] rnd_tlp();
    logic [TLP_W-1:0] v;
    v = '0;
    for (int i = 0; i < 38; i++) v = {v[TLP_W-33:0], 32'($urandom())};
    return v;
  endfunction

  function automatic logic [DLLP_W-1:0] rnd_dllp();
    return {32'($urandom()), 16'($urandom())};
  endfunction

  function automatic logic [2:0] rdy();
    return {bus.acknak_ready, bus.fc_ready, bus.tlp_ready};
  endfunction

  function automatic logic [TLP_W-1:0] payload_of(input int t);
    case (t)
      1:       return bus.tlp;
      2:       return TLP_W'(bus.acknak);
      3:       return TLP_W'(bus.fc);
      default: return '0;
    endcase
  endfunction

  task automatic drive(input logic [1:0] dlc, input logic av, input logic fv,
                       input logic tv, input logic pr);
    bus.dlc_state    = dlc;
    bus.acknak_valid = av;
    bus.fc_valid     = fv;
    bus.tlp_valid    = tv;
    bus.pkt_ready    = pr;
    bus.tlp          = rnd_tlp();
    bus.acknak       = rnd_dllp();
    bus.fc           = rnd_dllp();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    drive(2'b11, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
  endtask

  typedef struct {
    logic [1:0] dlc;
    logic       av, fv, tv;
    logic [2:0] exp_rdy;
    logic [1:0] exp_type;
  } vec_t;

  vec_t vecs[10];

  // Reference model state
  bit              m_hold;
  int              m_type;
  logic [TLP_W-1:0] m_pkt;
  int              m_cnt;

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [TLP_W-1:0] saved;
    int granted_at;
    int exp_at;

    vecs[0] = '{2'b00, 1'b1, 1'b1, 1'b1, 3'b000, 2'b00};
    vecs[1] = '{2'b01, 1'b1, 1'b1, 1'b1, 3'b000, 2'b00};
    vecs[2] = '{2'b10, 1'b1, 1'b1, 1'b1, 3'b010, 2'b11};
    vecs[3] = '{2'b11, 1'b1, 1'b1, 1'b1, 3'b100, 2'b10};
    vecs[4] = '{2'b11, 1'b0, 1'b1, 1'b1, 3'b010, 2'b11};
    vecs[5] = '{2'b11, 1'b0, 1'b0, 1'b1, 3'b001, 2'b01};
    vecs[6] = '{2'b10, 1'b0, 1'b0, 1'b1, 3'b000, 2'b00};
    vecs[7] = '{2'b10, 1'b1, 1'b0, 1'b0, 3'b000, 2'b00};
    vecs[8] = '{2'b11, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00};
    vecs[9] = '{2'b11, 1'b1, 1'b0, 1'b1, 3'b100, 2'b10};

    // Reset: outputs cleared and no readies even with requests pending
    drive(2'b11, 1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    tick();
    chk("rst_rdy", 64'(rdy()), 64'd0);
    chk("rst_valid", 64'(bus.pkt_valid), 64'd0);
    chk("rst_type", 64'(bus.pkt_type), 64'd0);
    chk_pkt("rst_pkt", '0);
    drive(2'b11, 1'b0, 1'b0, 1'b0, 1'b1);
    #2 rst_n = 1'b1;
    tick();

    // Single-decision vectors from an empty slot
    foreach (vecs[i]) begin
      drain();
      drive(vecs[i].dlc, vecs[i].av, vecs[i].fv, vecs[i].tv, 1'b1);
      @(negedge clk);
      chk($sformatf("vec%0d_rdy", i), 64'(rdy()), 64'(vecs[i].exp_rdy));
      saved = payload_of(int'(vecs[i].exp_type));
      tick();
      chk($sformatf("vec%0d_type", i), 64'(bus.pkt_type), 64'(vecs[i].exp_type));
      chk($sformatf("vec%0d_valid", i), 64'(bus.pkt_valid), 64'(vecs[i].exp_type != 2'b00));
      if (vecs[i].exp_type != 2'b00) chk_pkt($sformatf("vec%0d_pkt", i), saved);
    end

    // All three at once: Ack/Nak, FC, TLP back-to-back
    drain();
    drive(2'b11, 1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    chk("b2b_type0", 64'(bus.pkt_type), 64'(2'b10));
    bus.acknak_valid = 1'b0;
    tick();
    chk("b2b_type1", 64'(bus.pkt_type), 64'(2'b11));
    chk("b2b_valid1", 64'(bus.pkt_valid), 64'd1);
    bus.fc_valid = 1'b0;
    tick();
    chk("b2b_type2", 64'(bus.pkt_type), 64'(2'b01));
    chk("b2b_valid2", 64'(bus.pkt_valid), 64'd1);

    // DL_INIT: only FC may go; TLP stays blocked
    drain();
    drive(2'b10, 1'b0, 1'b1, 1'b1, 1'b1);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("init_tlp_rdy", 64'(bus.tlp_ready), 64'd0);
      chk("init_fc_rdy", 64'(bus.fc_ready), 64'd1);
      tick();
    end

    // Stall while holding a TLP
    drain();
    drive(2'b11, 1'b0, 1'b0, 1'b1, 1'b0);
    saved = bus.tlp;
    tick();
    drive(2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_rdy", 64'(rdy()), 64'd0);
      tick();
      chk_pkt("stall_pkt", saved);
      chk("stall_type", 64'(bus.pkt_type), 64'(2'b01));
    end
    drive(2'b11, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("stall_release_valid", 64'(bus.pkt_valid), 64'd0);
    chk("stall_release_type", 64'(bus.pkt_type), 64'd0);

    // Starvation under continuous FC traffic
    drain();
    drive(2'b11, 1'b0, 1'b1, 1'b1, 1'b1);
    granted_at = 0;
    for (int opp = 1; opp <= 40 && granted_at == 0; opp++) begin
      @(negedge clk);
      if (bus.tlp_ready) granted_at = opp;
      tick();
    end
    exp_at = STARVE ? LIMIT + 1 : 0;
    chk("starve_grant_opp", 64'(granted_at), 64'(exp_at));

    // Link drops out of DL_ACTIVE while a TLP is held
    drain();
    drive(2'b11, 1'b0, 1'b0, 1'b1, 1'b0);
    saved = bus.tlp;
    tick();
    chk("dlc_drop_type", 64'(bus.pkt_type), 64'(2'b01));
    drive(2'b10, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("dlc_drop_rdy", 64'(rdy()), 64'd0);
    tick();
    chk_pkt("dlc_drop_pkt", saved);
    chk("dlc_drop_valid", 64'(bus.pkt_valid), 64'd1);
    bus.pkt_ready = 1'b1;
    tick();
    chk("dlc_drop_done", 64'(bus.pkt_valid), 64'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("dlc_drop_no_tlp", 64'(bus.tlp_ready), 64'd0);
      tick();
    end

    // Asynchronous reset in the middle of HOLD
    drain();
    drive(2'b11, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("arst_pre_valid", 64'(bus.pkt_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(bus.pkt_valid), 64'd0);
    chk("arst_type", 64'(bus.pkt_type), 64'd0);
    chk("arst_rdy", 64'(rdy()), 64'd0);
    chk_pkt("arst_pkt", '0);
    drive(2'b11, 1'b0, 1'b0, 1'b0, 1'b1);
    #1 rst_n = 1'b1;
    tick();
    drain();

    // Randomized run against the reference model
    m_hold = 1'b0;
    m_type = 0;
    m_pkt  = '0;
    m_cnt  = 0;
    for (int n = 0; n < 400; n++) begin
      bit   elig[4];
      int   order[3];
      int   win;
      bit   opp;
      logic [1:0] d;
      d = ($urandom_range(0, 1) == 0) ? 2'b11 : 2'($urandom_range(0, 3));
      drive(d, 1'($urandom()), 1'($urandom()), 1'($urandom()), ($urandom_range(0, 3) != 0));
      elig[0] = 1'b0;
      elig[1] = bus.tlp_valid && (d == 2'b11);
      elig[2] = bus.acknak_valid && (d == 2'b11);
      elig[3] = bus.fc_valid && (d >= 2'b10);
      opp = !m_hold || bus.pkt_ready;
      if (STARVE && m_cnt >= LIMIT) order = '{2, 1, 3};
      else                          order = '{2, 3, 1};
      win = 0;
      if (opp) foreach (order[k]) if (win == 0 && elig[order[k]]) win = order[k];

      @(negedge clk);
      chk("rnd_rdy", 64'(rdy()), 64'({win == 2, win == 3, win == 1}));

      if (!bus.tlp_valid || win == 1) m_cnt = 0;
      else if (elig[1] && opp)        m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
      if (win != 0) begin
        m_hold = 1'b1;
        m_type = win;
        m_pkt  = payload_of(win);
      end else if (m_hold && bus.pkt_ready) begin
        m_hold = 1'b0;
        m_type = 0;
      end

      tick();
      chk("rnd_valid", 64'(bus.pkt_valid), 64'(m_hold));
      chk("rnd_type", 64'(bus.pkt_type), 64'(m_type));
      if (m_hold) chk_pkt("rnd_pkt", m_pkt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dll_tx_arbiter.md
DLL_TX_ARBITER -- requirements
Module: dll_tx_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 8, meaning the number of consecutive lost-arbitration cycles before a waiting TLP is promoted.
REQ-002 SHALL have port clk  input  1  single clock, rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port dlc_state_i  input  2  link state: 00 INACTIVE, 01 FEATURE, 10 DL_INIT, 11 DL_ACTIVE.
REQ-005 SHALL have port tlp_i  input  1196  framed TLP from the TX TLP generator: sequence number, TLP and LCRC.
REQ-006 SHALL have ports tlp_valid_i  input  1 and tlp_ready_o  output  1, forming the TLP handshake.
REQ-007 SHALL have ports acknak_i  input  48, acknak_valid_i  input  1 and acknak_ready_o  output  1, carrying Ack/Nak DLLPs.
REQ-008 SHALL have ports fc_i  input  48, fc_valid_i  input  1 and fc_ready_o  output  1, carrying InitFC/UpdateFC DLLPs.
REQ-009 SHALL have port pkt_o  output  1196  arbitrated packet; a DLLP occupies bits [47:0] and the upper bits are zero.
REQ-010 SHALL have port pkt_type_o  output  2  packet type: 00 none, 01 TLP, 10 Ack/Nak, 11 FC.
REQ-011 SHALL have ports pkt_valid_o  output  1 and pkt_ready_i  input  1, forming the downstream handshake.

Function
REQ-012 SHALL hold a single output register: pkt_o, pkt_type_o and pkt_valid_o are registered.
REQ-013 SHALL implement FSM states EMPTY and HOLD; reset enters EMPTY.
REQ-014 SHALL grant only when the FSM is in EMPTY, or when it is in HOLD with pkt_ready_i=1 in that cycle; the latter is back-to-back issue with zero bubble.
REQ-015 SHALL assert at most one *_ready_o per cycle, combinationally, only to the winner and only when that winner's valid is 1.
REQ-016 SHALL treat a transfer as a requester's valid and ready both being 1 in the same cycle; the payload is captured, pkt_valid_o=1 the next cycle (1-cycle latency), and the FSM goes to HOLD.
REQ-017 SHALL, from HOLD with pkt_ready_i=1 and no new grant, go to EMPTY and clear pkt_valid_o and pkt_type_o.
REQ-018 SHALL keep pkt_o and pkt_type_o stable while pkt_valid_o=1 and pkt_ready_i=0.
REQ-019 SHALL apply fixed priority Ack/Nak > FC > TLP.
REQ-020 SHALL allow TLP to be eligible only when dlc_state_i=11.
REQ-021 SHALL allow Ack/Nak to be eligible only when dlc_state_i=11.
REQ-022 SHALL allow FC to be eligible when dlc_state_i is 10 or 11.
REQ-023 SHALL make no grants while dlc_state_i is 00 or 01.
REQ-024 SHALL, when dlc_state_i leaves 11 while a TLP is in HOLD, still deliver the held packet and then make no further TLP grants.
REQ-025 SHALL keep the starvation counter 4 bits wide; it increments when tlp_valid_i=1, TLP is eligible and TLP loses a grant opportunity, saturates at 15, and clears on a TLP grant or when tlp_valid_i=0.

Reset
REQ-026 SHALL, on rst_n=0 and immediately (asynchronously), drive pkt_valid_o=0, pkt_type_o=00, pkt_o=0, FSM=EMPTY and starvation counter=0.
REQ-027 SHALL, on reset asserted mid-HOLD, discard the held packet; recovery is the requester's responsibility.
REQ-028 SHALL keep all *_ready_o at 0 while rst_n=0.

Configuration
REQ-029 SHALL, with DLL_TX_ARB_STARVE_EN defined, grant TLP ahead of FC (never ahead of Ack/Nak) once the starvation counter is >= STARVE_LIMIT.
REQ-030 SHALL, without DLL_TX_ARB_STARVE_EN, use pure fixed priority; the counter is not instantiated and STARVE_LIMIT is ignored.

Structure
REQ-031 SHALL place the DLC state encodings, packet type encodings, widths 1196 and 48, and the FSM state enum in package dll_pkg, shared with the TX TLP generator.
REQ-032 SHALL implement winner selection as combinational sub-module dll_tx_arb_pick (eligibility plus priority in, one-hot grant out); the FSM and registers remain in dll_tx_arbiter.

Verification
REQ-033 SHALL cover: dlc_state=11, all three valids=1 at once, pkt_ready_i=1 -> packet types issued over consecutive cycles are 10, 11, 01, with no bubble.
REQ-034 SHALL cover: dlc_state=10, tlp_valid=1, fc_valid=1 -> only FC is granted; tlp_ready_o stays 0 indefinitely.
REQ-035 SHALL cover: a TLP in HOLD with pkt_ready_i=0 for 5 cycles -> pkt_o is unchanged and no *_ready_o is asserted; pkt_ready_i=1 -> EMPTY on the next cycle.
REQ-036 SHALL cover, with DLL_TX_ARB_STARVE_EN and STARVE_LIMIT=8: fc_valid held at 1 and tlp_valid at 1 -> TLP is granted on the 9th grant opportunity; without the macro, TLP is never granted.
REQ-037 SHALL cover: rst_n dropped mid-HOLD, asynchronously between clock edges -> pkt_valid_o=0 before the next edge.
REQ-038 SHALL cover: dlc_state changing 11->10 during TLP HOLD -> the held TLP is delivered and subsequent TLP requests are not granted.
